accel_xyz_sampler: RTL and testbench
====================================

Name: accel_xyz_sampler

Overview:
Sequencer that sits directly upstream of the SPI single-register reader (read_reg) in the accelerometer path. On a periodic tick it commands three back-to-back register reads (X, Y, Z data), consumes each returned byte, and publishes a coherent XYZ sample with a one-cycle valid strobe to the display/processing logic. It also detects a stalled reader (timeout) and missed sample ticks (overrun).

Parameters:
SAMPLE_PERIOD, 1000000, ck cycles between sample ticks (10 ms at 100 MHz); minimum 2.
TIMEOUT, 4096, max ck cycles allowed in either wait state before abort.
REG_X, 8'h08, X data register address.
REG_Y, 8'h09, Y data register address.
REG_Z, 8'h0A, Z data register address.

Ports:
ck  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  sampling enable
rd_start  out  1  start request to the reader
rd_reg  out  8  register address to the reader
rd_data  in  8  byte returned by the reader
rd_ready  in  1  reader idle/done flag (high = idle, data valid)
x_out  out  8  last published X sample
y_out  out  8  last published Y sample
z_out  out  8  last published Z sample
sample_valid  out  1  one-cycle strobe: x/y/z_out updated this cycle
busy  out  1  high while a triple is in progress
timeout_err  out  1  one-cycle strobe on reader timeout
overrun  out  1  one-cycle strobe when a tick arrives while busy

Behaviour:
- Reset (rst high at a ck edge): all outputs 0, rd_reg = REG_X, state IDLE, period counter 0, axis index 0, timeout counter 0. rst overrides any state, including mid-transaction; rd_start drops on the same edge.
- Period counter: counts 0..SAMPLE_PERIOD-1 while enable=1, wraps to 0; tick = counter at SAMPLE_PERIOD-1. enable=0 holds the counter at 0 (no tick).
- FSM states: IDLE, REQ, WAIT_ACK, WAIT_DONE, STORE, PUBLISH.
- IDLE: busy=0. On tick, axis index=0, go REQ next cycle.
- REQ: rd_reg = REG_X/Y/Z per axis index (held stable until STORE completes); rd_start=1; go WAIT_ACK.
- WAIT_ACK: rd_start held 1 until rd_ready samples 0 (reader accepted), then rd_start=0, go WAIT_DONE.
- WAIT_DONE: rd_start=0; when rd_ready samples 1, go STORE.
- STORE: capture rd_data into internal shadow register for current axis. If axis<2: increment, go REQ. If axis=2: go PUBLISH.
- PUBLISH: copy all three shadows to x/y/z_out simultaneously; sample_valid=1 for exactly this cycle; go IDLE. Outputs hold between publishes.
- busy=1 in every state except IDLE.
- Timeout: counter clears on entry to WAIT_ACK and WAIT_DONE, increments each cycle in them; reaching TIMEOUT -> rd_start=0, timeout_err=1 for one cycle, shadows discarded, x/y/z_out unchanged, no sample_valid, return IDLE.
- Overrun: tick while busy=1 -> overrun=1 that cycle, tick dropped (no queued triple). Tick in the PUBLISH cycle also counts as overrun.
- enable dropped mid-triple: current triple completes and publishes; no further ticks.
- Latency from tick to sample_valid with a reader needing N cycles per read (ack + done): 3*(N+2)+2 cycles; rd_start never asserted while rd_ready=0 on entry to REQ.

Test Plan:
- Reset then enable=1, SAMPLE_PERIOD=100, behavioural reader returning rd_data=reg+8'h10 after 20 cycles -> rd_reg sequence 08,09,0A; sample_valid one cycle with x_out=18,y_out=19,z_out=1A; busy low afterwards.
- Two consecutive periods with reader data changed to 8'hA5/5A/C3 on second triple -> first outputs held until second PUBLISH, then A5/5A/C3 all on same cycle.
- Reader stuck with rd_ready=1 (never acks), TIMEOUT=50 -> rd_start high 50 cycles, timeout_err single pulse, rd_start low, no sample_valid, x/y/z_out unchanged.
- Reader taking 150 cycles per read with SAMPLE_PERIOD=100 -> overrun pulses during triple, only one triple in flight, sample still published correctly.
- rst asserted in WAIT_DONE of Y read -> next edge all outputs 0, state IDLE, rd_start 0; after release, a full triple publishes correctly.
- enable dropped during Z read -> triple publishes once, then no further rd_start for 3 periods.

Source files
------------

// File: rtl/accel_xyz_sampler.sv
// accel_xyz_sampler
// Periodically commands three single-register reads (X, Y, Z) from the SPI
// register reader and publishes the three bytes together as one coherent
// sample with a one-cycle valid strobe. Detects a stalled reader (timeout)
// and sample ticks that arrive while a triple is still running (overrun).
//
// Ports:
//   ck           system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   enable       sampling enable (gates the period counter)
//   rd_start     start request to the reader
//   rd_reg       register address to the reader
//   rd_data      byte returned by the reader
//   rd_ready     reader idle/done flag (high = idle, data valid)
//   x_out/y_out/z_out  last published sample
//   sample_valid one-cycle strobe, x/y/z_out carry a new sample this cycle
//   busy         high while a triple is in progress
//   timeout_err  one-cycle strobe on reader timeout
//   overrun      one-cycle strobe when a tick arrives while busy
module accel_xyz_sampler #(
  parameter int unsigned SAMPLE_PERIOD = 1000000,
  parameter int unsigned TIMEOUT       = 4096,
  parameter logic [7:0]  REG_X         = 8'h08,
  parameter logic [7:0]  REG_Y         = 8'h09,
  parameter logic [7:0]  REG_Z         = 8'h0A
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       enable,
  output logic       rd_start,
  output logic [7:0] rd_reg,
  input  logic [7:0] rd_data,
  input  logic       rd_ready,
  output logic [7:0] x_out,
  output logic [7:0] y_out,
  output logic [7:0] z_out,
  output logic       sample_valid,
  output logic       busy,
  output logic       timeout_err,
  output logic       overrun
);

  localparam int unsigned PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    STORE     = 3'd4,
    PUBLISH   = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   period_cnt_reg;
  logic [TW-1:0]   tcnt_reg;
  logic [1:0]      axis_reg;
  logic [7:0]      shadow_x_reg, shadow_y_reg;
  logic            tick;
  logic            timeout_hit;

  // Sample tick: last count of the period, only while enabled.
  assign tick = enable && (period_cnt_reg == PERIOD_LAST);

  always_ff @(posedge ck) begin
    if (rst || !enable || tick) period_cnt_reg <= '0;
    else                        period_cnt_reg <= period_cnt_reg + PW'(1);
  end

  // The wait-state budget runs out on the cycle the counter reaches its last
  // value while the awaited edge of rd_ready still has not appeared. A
  // reader response in that same cycle wins over the abort.
  always_comb begin
    timeout_hit = 1'b0;
    if (tcnt_reg == TIMEOUT_LAST) begin
      if (state_reg == WAIT_ACK  &&  rd_ready) timeout_hit = 1'b1;
      if (state_reg == WAIT_DONE && !rd_ready) timeout_hit = 1'b1;
    end
  end

  // State register
  always_ff @(posedge ck) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (tick) state_next = REQ;
      REQ:       state_next = WAIT_ACK;
      WAIT_ACK:  if (!rd_ready)       state_next = WAIT_DONE;
                 else if (timeout_hit) state_next = IDLE;
      WAIT_DONE: if (rd_ready)        state_next = STORE;
                 else if (timeout_hit) state_next = IDLE;
      STORE:     state_next = (axis_reg == 2'd2) ? PUBLISH : REQ;
      PUBLISH:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy         = (state_reg != IDLE);
    rd_start     = (state_reg == REQ) || (state_reg == WAIT_ACK && !timeout_hit);
    sample_valid = (state_reg == PUBLISH);
    timeout_err  = timeout_hit;
    overrun      = tick && busy;
    case (axis_reg)
      2'd0:    rd_reg = REG_X;
      2'd1:    rd_reg = REG_Y;
      default: rd_reg = REG_Z;
    endcase
  end

  // Datapath: wait counter, axis index, shadows and published outputs.
  always_ff @(posedge ck) begin
    if (rst) begin
      tcnt_reg     <= '0;
      axis_reg     <= 2'd0;
      shadow_x_reg <= 8'h00;
      shadow_y_reg <= 8'h00;
      x_out        <= 8'h00;
      y_out        <= 8'h00;
      z_out        <= 8'h00;
    end else begin
      // Any state change restarts the count, so each wait state starts at 0.
      if (state_next != state_reg)
        tcnt_reg <= '0;
      else if (state_reg == WAIT_ACK || state_reg == WAIT_DONE)
        tcnt_reg <= tcnt_reg + TW'(1);

      case (state_reg)
        IDLE: if (tick) axis_reg <= 2'd0;
        STORE: begin
          if (axis_reg == 2'd0) shadow_x_reg <= rd_data;
          if (axis_reg == 2'd1) shadow_y_reg <= rd_data;
          if (axis_reg != 2'd2) begin
            axis_reg <= axis_reg + 2'd1;
          end else begin
            // Z goes straight to its output so that all three outputs
            // change together on the edge into PUBLISH, i.e. they already
            // hold the new triple while sample_valid is high.
            x_out <= shadow_x_reg;
            y_out <= shadow_y_reg;
            z_out <= rd_data;
          end
        end
        WAIT_ACK, WAIT_DONE: begin
          if (timeout_hit) begin
            shadow_x_reg <= 8'h00;
            shadow_y_reg <= 8'h00;
            axis_reg     <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_xyz_sampler.sv
module tb_accel_xyz_sampler;

  localparam int PERIOD = 100;
  localparam int TMO    = 50;

  logic       ck = 1'b0;
  logic       rst;
  logic       enable;
  logic       rd_start;
  logic [7:0] rd_reg;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [7:0] x_out, y_out, z_out;
  logic       sample_valid, busy, timeout_err, overrun;

  accel_xyz_sampler #(
    .SAMPLE_PERIOD(PERIOD),
    .TIMEOUT(TMO),
    .REG_X(8'h08),
    .REG_Y(8'h09),
    .REG_Z(8'h0A)
  ) dut (
    .ck(ck), .rst(rst), .enable(enable),
    .rd_start(rd_start), .rd_reg(rd_reg), .rd_data(rd_data), .rd_ready(rd_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .sample_valid(sample_valid), .busy(busy),
    .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 ck = ~ck;

  // Reader model configuration (set by the main sequence while idle).
  logic [7:0] tbl [3];
  int         ack_dly;
  int         done_dly;
  bit         stuck;

  // Scoreboard / monitor state, owned by the main sequence.
  int         tests = 0;
  int         fails = 0;
  int         n_valid = 0, n_to = 0, n_ov = 0, n_starts = 0, start_cyc = 0;
  logic [7:0] hold_x = 8'h00, hold_y = 8'h00, hold_z = 8'h00;
  int         axis_exp = 0;
  logic       prev_start = 1'b0, prev_sv = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural reader: accepts a request while idle, drops ready after
  // ack_dly cycles, returns tbl[reg-8] and raises ready after done_dly more.
  initial begin
    logic [7:0] lat_reg;
    logic [7:0] idx;
    rd_ready = 1'b1;
    rd_data  = 8'h00;
    forever begin
      @(posedge ck); #1;
      if (rd_start && rd_ready && !stuck) begin
        lat_reg = rd_reg;
        repeat (ack_dly - 1) @(posedge ck);
        #1 rd_ready = 1'b0;
        repeat (done_dly) @(posedge ck);
        #1;
        idx      = lat_reg - 8'h08;
        rd_data  = tbl[idx[1:0]];
        rd_ready = 1'b1;
      end
    end
  end

  // One clock of observation at the falling edge, with all per-cycle checks.
  task automatic step();
    @(negedge ck);
    if (rst) begin
      check("rst_state",
            {x_out, y_out, z_out, rd_reg, sample_valid, busy, rd_start, timeout_err, overrun},
            {24'h000000, 8'h08, 5'b00000});
      hold_x = 8'h00; hold_y = 8'h00; hold_z = 8'h00;
      axis_exp   = 0;
      prev_start = 1'b0;
      prev_sv    = 1'b0;
      return;
    end
    if (sample_valid) begin
      n_valid++;
      check("pub_xyz", {x_out, y_out, z_out}, {tbl[0], tbl[1], tbl[2]});
      check("sv_single", prev_sv, 1'b0);
      hold_x = tbl[0]; hold_y = tbl[1]; hold_z = tbl[2];
    end else if ({x_out, y_out, z_out} !== {hold_x, hold_y, hold_z}) begin
      check("hold_xyz", {x_out, y_out, z_out}, {hold_x, hold_y, hold_z});
    end
    if (timeout_err) begin
      n_to++;
      axis_exp = 0;
    end
    if (overrun) begin
      n_ov++;
      check("ov_busy", busy, 1'b1);
    end
    if (rd_start) begin
      start_cyc++;
      if (!prev_start) begin
        n_starts++;
        check("rd_reg_seq", rd_reg, 8'h08 + 8'(axis_exp));
        axis_exp = (axis_exp + 1) % 3;
      end
    end
    prev_start = rd_start;
    prev_sv    = sample_valid;
  endtask

  task automatic wait_valid(input int target, input int budget, input string tag);
    int n = 0;
    while (n_valid < target && n < budget) begin
      step();
      n++;
    end
    if (n_valid < target) check(tag, 64'(n_valid), 64'(target));
  endtask

  task automatic randomize_tbl();
    for (int i = 0; i < 3; i++) tbl[i] = 8'($urandom);
  endtask

  initial begin
    int v0, s0, o0, t0, c0, n;
    rst = 1'b1; enable = 1'b0; stuck = 1'b0;
    ack_dly = 5; done_dly = 15;
    tbl[0] = 8'h18; tbl[1] = 8'h19; tbl[2] = 8'h1A;

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    step();
    check("idle_busy", busy, 1'b0);

    // First triple: 20-cycle reader returning reg+0x10
    enable = 1'b1;
    wait_valid(1, 400, "t1_valid_wait");
    step();
    check("t1_busy_after", busy, 1'b0);
    check("t1_starts", 64'(n_starts), 64'd3);

    // Second triple with new data; first sample held until it publishes
    tbl[0] = 8'hA5; tbl[1] = 8'h5A; tbl[2] = 8'hC3;
    wait_valid(2, 400, "t2_valid_wait");
    // Third triple with random data and random reader timing
    while (busy) step();
    randomize_tbl();
    ack_dly  = $urandom_range(1, 10);
    done_dly = $urandom_range(1, 20);
    wait_valid(3, 400, "t3_valid_wait");
    enable = 1'b0;
    step();

    // Stuck reader: rd_start high TIMEOUT cycles, single timeout pulse
    stuck = 1'b1;
    v0 = n_valid; c0 = start_cyc; t0 = n_to;
    enable = 1'b1;
    n = 0;
    while (n_to == t0 && n < 300) begin step(); n++; end
    enable = 1'b0;
    check("to_seen", 64'(n_to - t0), 64'd1);
    check("to_start_cycles", 64'(start_cyc - c0), 64'(TMO));
    step();
    check("to_rd_start_low", rd_start, 1'b0);
    check("to_idle", busy, 1'b0);
    repeat (150) step();
    check("to_single_pulse", 64'(n_to - t0), 64'd1);
    check("to_no_valid", 64'(n_valid - v0), 64'd0);
    stuck = 1'b0;

    // Slow reader: triple outlasts the period, overrun while busy
    randomize_tbl();
    ack_dly  = $urandom_range(10, 25);
    done_dly = $urandom_range(30, 40);
    v0 = n_valid; s0 = n_starts; o0 = n_ov;
    enable = 1'b1;
    n = 0;
    while (n_ov == o0 && n < 400) begin step(); n++; end
    enable = 1'b0;
    check("ov_seen", 64'(n_ov - o0), 64'd1);
    wait_valid(v0 + 1, 400, "ov_valid_wait");
    repeat (250) step();
    check("ov_one_triple", 64'(n_starts - s0), 64'd3);
    check("ov_one_valid", 64'(n_valid - v0), 64'd1);
    check("ov_count", 64'(n_ov - o0), 64'd1);

    // Reset during the Y read's WAIT_DONE, then a clean triple
    randomize_tbl();
    ack_dly  = $urandom_range(2, 8);
    done_dly = $urandom_range(20, 30);
    v0 = n_valid;
    enable = 1'b1;
    n = 0;
    while (!(rd_start && rd_reg == 8'h09) && n < 400) begin step(); n++; end
    while (rd_start && n < 400) begin step(); n++; end
    check("rst_reached_y_wait", {rd_reg, busy, rd_start}, {8'h09, 2'b10});
    rst = 1'b1;
    step();
    rst = 1'b0; enable = 1'b0;
    n = 0;
    while (!rd_ready && n < 100) begin step(); n++; end
    check("rst_reader_idle", rd_ready, 1'b1);
    check("rst_no_valid", 64'(n_valid - v0), 64'd0);
    randomize_tbl();
    enable = 1'b1;
    wait_valid(v0 + 1, 400, "rst_valid_wait");
    enable = 1'b0;
    step();

    // enable dropped during Z read: triple completes, then nothing
    randomize_tbl();
    v0 = n_valid;
    enable = 1'b1;
    n = 0;
    while (!(rd_start && rd_reg == 8'h0A) && n < 400) begin step(); n++; end
    enable = 1'b0;
    wait_valid(v0 + 1, 200, "en_valid_wait");
    s0 = n_starts; v0 = n_valid;
    repeat (3 * PERIOD) step();
    check("en_no_starts", 64'(n_starts - s0), 64'd0);
    check("en_no_valid", 64'(n_valid - v0), 64'd0);
    check("en_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
